// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, with fast paths for divide-by-zero and signed overflow.
//
// state | meaning
// IDLE  | waiting for start; operands latched on accept
// CALC  | one multiply/divide iteration per cycle on operand magnitudes
// FIX   | sign correction and result selection
// DONE  | result handed to output; done pulses on the following cycle
module muldiv_unit #(
    parameter int WORD_SIZE = 32,
    parameter int CNT_W     = $clog2(WORD_SIZE) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    input  logic                 flush,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] result
);

    localparam logic [WORD_SIZE-1:0] ALL_ONES = '1;
    localparam logic [WORD_SIZE-1:0] MIN_NEG  = {1'b1, {(WORD_SIZE-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [2:0]              op_q;
    logic [2*WORD_SIZE-1:0]  prod;
    logic [WORD_SIZE-1:0]    opb_mag;
    logic                    neg_res;
    logic                    neg_rem;
    logic [WORD_SIZE-1:0]    res_q;

    logic                    sign_a, sign_b;
    logic                    div_zero, div_ovf, special;
    logic [WORD_SIZE-1:0]    special_res;
    logic [WORD_SIZE:0]      mul_sum;
    logic [2*WORD_SIZE-1:0]  mul_step;
    logic [WORD_SIZE:0]      div_shift, div_diff;
    logic [2*WORD_SIZE-1:0]  div_step;
    logic [2*WORD_SIZE-1:0]  prod_s;
    logic [WORD_SIZE-1:0]    quo_s, rem_s, fix_res;

    // Operand signedness and special cases, evaluated on the live inputs at accept
    always_comb begin
        sign_a      = a[WORD_SIZE-1] & (op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd6);
        sign_b      = b[WORD_SIZE-1] & (op == 3'd1 || op == 3'd4 || op == 3'd6);
        div_zero    = op[2] && (b == '0);
        div_ovf     = op[2] && !op[0] && (a == MIN_NEG) && (b == ALL_ONES);
        special     = div_zero || div_ovf;
        if (div_zero)
            special_res = op[1] ? a : ALL_ONES;
        else
            special_res = op[1] ? '0 : a;
    end

    // Multiply keeps the multiplier in the low half and shifts the product in from the top;
    // divide keeps {remainder, dividend/quotient} in the same register.
    always_comb begin
        mul_sum   = {1'b0, prod[2*WORD_SIZE-1:WORD_SIZE]} + {1'b0, (prod[0] ? opb_mag : '0)};
        mul_step  = {mul_sum, prod[WORD_SIZE-1:1]};
        div_shift = prod[2*WORD_SIZE-1:WORD_SIZE-1];
        div_diff  = div_shift - {1'b0, opb_mag};
        if (div_diff[WORD_SIZE])
            div_step = {div_shift[WORD_SIZE-1:0], prod[WORD_SIZE-2:0], 1'b0};
        else
            div_step = {div_diff[WORD_SIZE-1:0], prod[WORD_SIZE-2:0], 1'b1};
    end

    always_comb begin
        prod_s = neg_res ? -prod : prod;
        quo_s  = neg_res ? -prod[WORD_SIZE-1:0] : prod[WORD_SIZE-1:0];
        rem_s  = neg_rem ? -prod[2*WORD_SIZE-1:WORD_SIZE] : prod[2*WORD_SIZE-1:WORD_SIZE];
        case (op_q)
            3'd0:             fix_res = prod_s[WORD_SIZE-1:0];
            3'd1, 3'd2, 3'd3: fix_res = prod_s[2*WORD_SIZE-1:WORD_SIZE];
            3'd4, 3'd5:       fix_res = quo_s;
            default:          fix_res = rem_s;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        case (state)
            IDLE: if (start) state_nxt = special ? DONE : CALC;
            CALC: if (cnt == CNT_W'(1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            op_q    <= '0;
            prod    <= '0;
            opb_mag <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            res_q   <= '0;
            result  <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!flush) begin
                case (state)
                    IDLE: if (start) begin
                        op_q    <= op;
                        neg_res <= sign_a ^ sign_b;
                        neg_rem <= sign_a;
                        opb_mag <= sign_b ? -b : b;
                        prod    <= {{WORD_SIZE{1'b0}}, (sign_a ? -a : a)};
                        cnt     <= special ? '0 : CNT_W'(WORD_SIZE);
                        if (special)
                            res_q <= special_res;
                    end
                    CALC: begin
                        cnt  <= cnt - CNT_W'(1);
                        prod <= op_q[2] ? div_step : mul_step;
                    end
                    FIX:  res_q <= fix_res;
                    DONE: begin
                        result <= res_q;
                        done   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
